uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters; legal values 2..8.
REQ-002 Parameter BAUD_INIT, default 16'd103, value written to the UART baud register after reset.
REQ-003 Parameter CON_INIT, default 16'h0003, value written to the UART control register after reset (bit0 enable, bit1 txie).
REQ-004 Parameter TIMEOUT, default 16'hFFFF, number of WAIT cycles allowed before a byte is abandoned.
REQ-005 sys_clk  in  1  single block clock; all logic is on its rising edge.
REQ-006 sys_rst  in  1  reset, synchronous and active-high.
REQ-007 req_valid  in  NREQ  per-requester byte-pending flag.
REQ-008 req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-009 req_ready  out  NREQ  one-cycle accept pulse per requester.
REQ-010 uart_tx_done  in  1  single-cycle pulse from the UART when the stop bit completes.
REQ-011 uart_baud_wr, uart_con_wr, uart_txbuf_wr  out  1 each  register write strobes to the UART.
REQ-012 icb_wdat  out  16  write data accompanying the strobes.
REQ-013 cfg_done  out  1  high once the configuration writes have completed.
REQ-014 busy  out  1  high in ISSUE and WAIT.
REQ-015 grant_id  out  3  index of the last granted requester.
REQ-016 timeout_err  out  1  sticky timeout flag.
REQ-017 err_clr  in  1  clears timeout_err.

Function
REQ-018 FSM states: CFG_BAUD, CFG_CON, IDLE, ISSUE, WAIT; all outputs are registered.
REQ-019 CFG_BAUD lasts exactly one cycle: uart_baud_wr=1, icb_wdat=BAUD_INIT, next state CFG_CON.
REQ-020 CFG_CON lasts exactly one cycle: uart_con_wr=1, icb_wdat=CON_INIT; cfg_done is set on exit; next state IDLE.
REQ-021 In IDLE with any req_valid high, the arbiter selects round-robin, starting at the index after grant_id and wrapping at NREQ-1→0; next state ISSUE.
REQ-022 ISSUE lasts exactly one cycle: uart_txbuf_wr=1, req_ready[sel]=1, icb_wdat={8'h00, req_data[sel]}, grant_id=sel.
REQ-023 ISSUE timing: req_valid sampled high in cycle N produces the write strobe in cycle N+1.
REQ-024 A requester holds valid and data stable until its ready pulse; valid dropped before grant is legal and is simply not served.
REQ-025 WAIT clears a 16-bit counter on entry and increments it each cycle.
REQ-026 In WAIT, uart_tx_done returns the FSM to IDLE.
REQ-027 In WAIT, counter==TIMEOUT-1 without done sets timeout_err and returns the FSM to IDLE.
REQ-028 If done and timeout occur in the same cycle, done wins and timeout_err is not set.
REQ-029 uart_tx_done outside WAIT is ignored.
REQ-030 err_clr clears timeout_err; a simultaneous set wins over the clear.
REQ-031 Outside the states that drive them, all strobes and req_ready are 0 and icb_wdat is 16'h0000.
REQ-032 At most one strobe and at most one req_ready bit are high in any cycle.

Reset
REQ-033 While sys_rst is high, state=CFG_BAUD and all outputs are 0: strobes, icb_wdat, req_ready, cfg_done, busy, timeout_err; grant_id=NREQ-1 so the first grant search starts at requester 0.
REQ-034 Reset asserted mid-operation (ISSUE/WAIT) abandons the byte without a ready pulse; the configuration sequence reruns in the first two cycles after release.

Structure
REQ-035 FSM state encodings and the UART control bit positions (enable, txie) belong in shared package uart_pkg.
REQ-036 The round-robin selector is one sub-module, uart_rr_arb (inputs: request vector, last grant; output: selected index plus valid), combinational.

Verification
REQ-037 Reset release -> cycle 1 uart_baud_wr with icb_wdat=0x0067; cycle 2 uart_con_wr with 0x0003; cycle 3 cfg_done=1.
REQ-038 req_valid=4'b0001, data0=0xA5 -> txbuf_wr with icb_wdat=0x00A5 one cycle after IDLE sample, ready[0] in the same cycle; done 20 cycles later -> IDLE, busy=0.
REQ-039 All four requesters valid continuously, done returned each time -> grant order 0,1,2,3,0; no requester is starved.
REQ-040 TIMEOUT=16, no done -> timeout_err=1 after 16 WAIT cycles, then IDLE; err_clr -> timeout_err=0.
REQ-041 Done and the timeout boundary in the same cycle -> timeout_err stays 0.
REQ-042 sys_rst pulsed during WAIT -> no ready pulse for the abandoned byte, config writes repeat, pending requesters are served afterwards starting from index 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, control
// register bit positions and the round-robin index helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_CFG_BAUD = 3'd0,
    ST_CFG_CON  = 3'd1,
    ST_IDLE     = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT     = 3'd4
  } uart_state_t;

  // UART control register bit positions
  localparam int CON_EN_BIT   = 0;
  localparam int CON_TXIE_BIT = 1;

  // Control word with transmitter and tx interrupt both enabled
  localparam logic [15:0] CON_DEFAULT = 16'((1 << CON_EN_BIT) | (1 << CON_TXIE_BIT));

  // Width of the WAIT-state cycle counter
  localparam int CNT_W = 16;

  // Index reached by stepping 'step' places after 'base' in a ring of n entries
  function automatic logic [2:0] rr_wrap(input logic [2:0] base, input int step, input int n);
    int t;
    t = int'(base) + step;
    if (t >= n) t = t - n;
    return t[2:0];
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin selector: searches the request vector starting
// one place after the last grant and wrapping at NREQ-1 back to 0.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [2:0]      sel,
  output logic            vld
);

  // First pending requester in rotating priority order after 'last'
  always_comb begin
    sel = '0;
    vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld && req[i] && (rr_wrap(last, k, NREQ) == 3'(i))) begin
          sel = 3'(i);
          vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Multi-requester UART byte transmitter front end. Programs the UART baud and
// control registers after reset, then hands bytes from NREQ requesters to the
// UART tx buffer one at a time in round-robin order, waiting for tx_done (or
// a timeout) between bytes.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int          NREQ      = 4,
  parameter logic [15:0] BAUD_INIT = 16'd103,
  parameter logic [15:0] CON_INIT  = CON_DEFAULT,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              uart_tx_done,
  output logic              uart_baud_wr,
  output logic              uart_con_wr,
  output logic              uart_txbuf_wr,
  output logic [15:0]       icb_wdat,
  output logic              cfg_done,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic              timeout_err,
  input  logic              err_clr
);

  uart_state_t      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       arb_sel;
  logic             arb_vld;
  logic [7:0]       sel_data;
  logic [NREQ-1:0]  sel_onehot;

  uart_rr_arb #(
    .NREQ(NREQ)
  ) u_rr_arb (
    .req  (req_valid),
    .last (grant_id),
    .sel  (arb_sel),
    .vld  (arb_vld)
  );

  // Byte and ready mask belonging to the currently selected requester
  always_comb begin
    sel_data   = 8'h00;
    sel_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_sel == 3'(i)) begin
        sel_data      = req_data[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Control FSM; every output is a register and strobes default low each cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_CFG_BAUD;
      wait_cnt      <= '0;
      req_ready     <= '0;
      uart_baud_wr  <= 1'b0;
      uart_con_wr   <= 1'b0;
      uart_txbuf_wr <= 1'b0;
      icb_wdat      <= 16'h0000;
      cfg_done      <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= 3'(NREQ - 1);
      timeout_err   <= 1'b0;
    end else begin
      uart_baud_wr  <= 1'b0;
      uart_con_wr   <= 1'b0;
      uart_txbuf_wr <= 1'b0;
      req_ready     <= '0;
      icb_wdat      <= 16'h0000;
      // Clear first so a timeout in the same cycle overrides it below
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        ST_CFG_BAUD: begin
          uart_baud_wr <= 1'b1;
          icb_wdat     <= BAUD_INIT;
          state        <= ST_CFG_CON;
        end
        ST_CFG_CON: begin
          uart_con_wr <= 1'b1;
          icb_wdat    <= CON_INIT;
          state       <= ST_IDLE;
        end
        ST_IDLE: begin
          cfg_done <= 1'b1;
          if (arb_vld) begin
            uart_txbuf_wr <= 1'b1;
            req_ready     <= sel_onehot;
            icb_wdat      <= {8'h00, sel_data};
            grant_id      <= arb_sel;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over the timeout boundary
          if (uart_tx_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (wait_cnt == TIMEOUT - 16'd1) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= ST_CFG_BAUD;
      endcase
    end
  end

endmodule
